// File: rtl/ctrl_sequencer_pkg.sv
// Shared encodings for the MiniSRC multi-cycle control sequencer:
// FSM states, opcodes, ALU operations, writeback selects and branch conditions.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_FAULT  = 3'd7
    } state_e;

    typedef enum logic [3:0] {
        CL_ALU     = 4'd0,
        CL_HILO    = 4'd1,
        CL_LOAD    = 4'd2,
        CL_LOADI   = 4'd3,
        CL_STORE   = 4'd4,
        CL_BRANCH  = 4'd5,
        CL_JAL     = 4'd6,
        CL_JR      = 4'd7,
        CL_MOVE    = 4'd8,
        CL_NOP     = 4'd9,
        CL_HALT    = 4'd10,
        CL_ILLEGAL = 4'd11
    } op_class_e;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROTR = 5'b00111;
    localparam logic [4:0] OP_ROTL = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JAL  = 5'b10100;
    localparam logic [4:0] OP_JR   = 5'b10101;
    localparam logic [4:0] OP_MFLO = 5'b11000;
    localparam logic [4:0] OP_MFHI = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11011;
    localparam logic [4:0] OP_HALT = 5'b11100;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_ROTR = 4'd4;
    localparam logic [3:0] ALU_ROTL = 4'd5;
    localparam logic [3:0] ALU_SHR  = 4'd6;
    localparam logic [3:0] ALU_SHRA = 4'd7;
    localparam logic [3:0] ALU_SHL  = 4'd8;
    localparam logic [3:0] ALU_DIV  = 4'd9;
    localparam logic [3:0] ALU_MUL  = 4'd10;
    localparam logic [3:0] ALU_NEG  = 4'd11;
    localparam logic [3:0] ALU_NOT  = 4'd12;

    localparam logic [2:0] SEL_ALU = 3'd0;
    localparam logic [2:0] SEL_HI  = 3'd1;
    localparam logic [2:0] SEL_MEM = 3'd2;
    localparam logic [2:0] SEL_LO  = 3'd3;
    localparam logic [2:0] SEL_PC  = 3'd4;

    localparam logic [1:0] COND_ZERO  = 2'b00;
    localparam logic [1:0] COND_POS   = 2'b01;
    localparam logic [1:0] COND_NZERO = 2'b10;
    localparam logic [1:0] COND_NEG   = 2'b11;

    function automatic logic branch_taken(input logic [1:0] cond, input logic zero, input logic neg);
        logic taken;
        case (cond)
            COND_ZERO:  taken = zero;
            COND_NZERO: taken = ~zero;
            COND_POS:   taken = ~neg;
            COND_NEG:   taken = neg;
            default:    taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/ctrl_sequencer_if.sv
// Instruction/memory handshake and datapath control bundle between the
// sequencer (master) and the datapath/memory side (slave).
interface ctrl_sequencer_if #(
    parameter int IR_W = 32
) ();
    logic [IR_W-1:0] ir;
    logic            zero;
    logic            rz_b31;
    logic            mem_ready;
    logic            mem_rd;
    logic            mem_wr;
    logic            ir_enable;
    logic            pc_enable;
    logic            pc_load;
    logic            ra_enable;
    logic            rb_enable;
    logic            rz_enable;
    logic            hilo_enable;
    logic            rf_write;
    logic [3:0]      alu_control;
    logic [2:0]      my_select;

    modport master (
        input  ir, zero, rz_b31, mem_ready,
        output mem_rd, mem_wr, ir_enable, pc_enable, pc_load, ra_enable, rb_enable,
               rz_enable, hilo_enable, rf_write, alu_control, my_select
    );

    modport slave (
        output ir, zero, rz_b31, mem_ready,
        input  mem_rd, mem_wr, ir_enable, pc_enable, pc_load, ra_enable, rb_enable,
               rz_enable, hilo_enable, rf_write, alu_control, my_select
    );
endinterface

// File: rtl/ctrl_sequencer_decode.sv
// Combinational opcode decoder: instruction class, ALU operation and
// writeback mux select for the sequencer.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OP_W = 5
) (
    input  logic [OP_W-1:0] opcode,
    output op_class_e       op_class,
    output logic [3:0]      alu_op,
    output logic [2:0]      wb_sel
);

    // Opcode lookup; anything not listed is treated as illegal.
    always_comb begin
        op_class = CL_ILLEGAL;
        alu_op   = ALU_ADD;
        wb_sel   = SEL_ALU;
        case (opcode)
            OP_LD:   begin op_class = CL_LOAD;  wb_sel = SEL_MEM; end
            OP_LDI:  begin op_class = CL_LOADI; wb_sel = SEL_MEM; end
            OP_ST:   op_class = CL_STORE;
            OP_ADD:  op_class = CL_ALU;
            OP_SUB:  begin op_class = CL_ALU; alu_op = ALU_SUB;  end
            OP_AND:  begin op_class = CL_ALU; alu_op = ALU_AND;  end
            OP_OR:   begin op_class = CL_ALU; alu_op = ALU_OR;   end
            OP_ROTR: begin op_class = CL_ALU; alu_op = ALU_ROTR; end
            OP_ROTL: begin op_class = CL_ALU; alu_op = ALU_ROTL; end
            OP_SHR:  begin op_class = CL_ALU; alu_op = ALU_SHR;  end
            OP_SHRA: begin op_class = CL_ALU; alu_op = ALU_SHRA; end
            OP_SHL:  begin op_class = CL_ALU; alu_op = ALU_SHL;  end
            OP_ADDI: op_class = CL_ALU;
            OP_ANDI: begin op_class = CL_ALU; alu_op = ALU_AND;  end
            OP_ORI:  begin op_class = CL_ALU; alu_op = ALU_OR;   end
            OP_DIV:  begin op_class = CL_HILO; alu_op = ALU_DIV; end
            OP_MUL:  begin op_class = CL_HILO; alu_op = ALU_MUL; end
            OP_NEG:  begin op_class = CL_ALU; alu_op = ALU_NEG;  end
            OP_NOT:  begin op_class = CL_ALU; alu_op = ALU_NOT;  end
            OP_BR:   op_class = CL_BRANCH;
            OP_JAL:  begin op_class = CL_JAL; wb_sel = SEL_PC; end
            OP_JR:   op_class = CL_JR;
            OP_MFLO: begin op_class = CL_MOVE; wb_sel = SEL_LO; end
            OP_MFHI: begin op_class = CL_MOVE; wb_sel = SEL_HI; end
            OP_NOP:  op_class = CL_NOP;
            OP_HALT: op_class = CL_HALT;
            default: op_class = CL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// MiniSRC multi-cycle control FSM: variable-length instruction sequencing,
// memory-ready stalls with timeout, halt/fault trapping and retire counting.
module ctrl_sequencer
    import ctrl_pkg::*;
#(
    parameter int IR_W        = 32,
    parameter int OP_W        = 5,
    parameter int COND_LSB    = 21,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clock,
    input  logic             nRst,
    ctrl_sequencer_if.master bus,
    output logic [2:0]       state,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] instr_count
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_e            state_r;
    state_e            next_state_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [WAIT_W-1:0] wait_cnt_next_s;
    logic [CNT_W-1:0]  count_r;
    logic              halted_r;
    logic              fault_r;
    logic              retire_s;
    logic              timeout_s;
    logic              taken_s;
    logic              pc_jump_s;
    logic [OP_W-1:0]   opcode_s;
    logic [1:0]        cond_s;
    op_class_e         op_class_s;
    logic [3:0]        alu_op_s;
    logic [2:0]        wb_sel_s;

    assign opcode_s  = bus.ir[IR_W-1 -: OP_W];
    assign cond_s    = bus.ir[COND_LSB+1:COND_LSB];
    assign taken_s   = branch_taken(cond_s, bus.zero, bus.rz_b31);
    assign timeout_s = (wait_cnt_r == WAIT_LAST);
    assign pc_jump_s = (op_class_s == CL_JAL) || (op_class_s == CL_JR) ||
                       ((op_class_s == CL_BRANCH) && taken_s);

    ctrl_decode #(.OP_W(OP_W)) u_decode (
        .opcode   (opcode_s),
        .op_class (op_class_s),
        .alu_op   (alu_op_s),
        .wb_sel   (wb_sel_s)
    );

    // State, wait counter, retire counter and sticky status registers.
    always_ff @(posedge clock or negedge nRst) begin
        if (!nRst) begin
            state_r    <= S_IDLE;
            wait_cnt_r <= {WAIT_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            halted_r   <= 1'b0;
            fault_r    <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            wait_cnt_r <= wait_cnt_next_s;
            count_r    <= retire_s ? count_r + CNT_W'(1) : count_r;
            halted_r   <= halted_r | (next_state_s == S_HALT);
            fault_r    <= fault_r | (next_state_s == S_FAULT);
        end
    end

    // Next-state, retire and wait-counter logic.
    always_comb begin
        next_state_s    = state_r;
        retire_s        = 1'b0;
        wait_cnt_next_s = {WAIT_W{1'b0}};
        case (state_r)
            S_IDLE:   next_state_s = S_FETCH;
            S_FETCH: begin
                if (bus.mem_ready)  next_state_s = S_DECODE;
                else if (timeout_s) next_state_s = S_FAULT;
                else                next_state_s = S_FETCH;
            end
            S_DECODE: begin
                case (op_class_s)
                    CL_NOP:     begin next_state_s = S_FETCH; retire_s = 1'b1; end
                    CL_HALT:    next_state_s = S_HALT;
                    CL_ILLEGAL: next_state_s = S_FAULT;
                    default:    next_state_s = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (op_class_s)
                    CL_LOAD, CL_STORE:     next_state_s = S_MEM;
                    CL_HILO, CL_BRANCH,
                    CL_JR:                 begin next_state_s = S_FETCH; retire_s = 1'b1; end
                    default:               next_state_s = S_WB;
                endcase
            end
            S_MEM: begin
                if (!bus.mem_ready) begin
                    next_state_s = timeout_s ? S_FAULT : S_MEM;
                end else if (op_class_s == CL_STORE) begin
                    next_state_s = S_FETCH;
                    retire_s     = 1'b1;
                end else begin
                    next_state_s = S_WB;
                end
            end
            S_WB:     begin next_state_s = S_FETCH; retire_s = 1'b1; end
            S_HALT:   next_state_s = S_HALT;
            S_FAULT:  next_state_s = S_FAULT;
            default:  next_state_s = S_FAULT;
        endcase
        // Only a continued stall in the same memory state keeps counting.
        if (((state_r == S_FETCH) || (state_r == S_MEM)) && !bus.mem_ready &&
            (next_state_s == state_r)) begin
            wait_cnt_next_s = wait_cnt_r + WAIT_W'(1);
        end else begin
            wait_cnt_next_s = {WAIT_W{1'b0}};
        end
    end

    // Strobes decode from the registered state so reset clears them at once.
    always_comb begin
        bus.mem_rd      = 1'b0;
        bus.mem_wr      = 1'b0;
        bus.ir_enable   = 1'b0;
        bus.pc_enable   = 1'b0;
        bus.pc_load     = 1'b0;
        bus.ra_enable   = 1'b0;
        bus.rb_enable   = 1'b0;
        bus.rz_enable   = 1'b0;
        bus.hilo_enable = 1'b0;
        bus.rf_write    = 1'b0;
        bus.alu_control = 4'd0;
        bus.my_select   = 3'd0;
        case (state_r)
            S_FETCH: begin
                bus.mem_rd    = 1'b1;
                bus.ir_enable = bus.mem_ready;
                bus.pc_enable = bus.mem_ready;
            end
            S_DECODE: begin
                bus.ra_enable = 1'b1;
                bus.rb_enable = 1'b1;
            end
            S_EXEC: begin
                bus.rz_enable   = 1'b1;
                bus.alu_control = alu_op_s;
                bus.hilo_enable = (op_class_s == CL_HILO);
                bus.pc_enable   = pc_jump_s;
                bus.pc_load     = pc_jump_s;
            end
            S_MEM: begin
                bus.mem_rd = (op_class_s == CL_LOAD);
                bus.mem_wr = (op_class_s == CL_STORE);
            end
            S_WB: begin
                bus.rf_write  = 1'b1;
                bus.my_select = wb_sel_s;
            end
            default: bus.rf_write = 1'b0;
        endcase
    end

    assign state       = state_r;
    assign halted      = halted_r;
    assign fault       = fault_r;
    assign instr_count = count_r;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Scoreboard bench for ctrl_sequencer: an instruction-level reference model
// queues the expected per-cycle control vector, a monitor compares each cycle.
module tb_ctrl_sequencer;

    localparam int TO = 15;
    localparam int CW = 4;

    typedef struct packed {
        logic [2:0]    st;
        logic          mem_rd, mem_wr, ir_en, pc_en, pc_ld, ra, rb, rz, hilo, rfw;
        logic [3:0]    alu;
        logic [2:0]    sel;
        logic          hlt, flt;
        logic [CW-1:0] cnt;
    } obs_t;

    logic          clock = 1'b0;
    logic          nRst  = 1'b0;
    logic [2:0]    state;
    logic          halted, fault;
    logic [CW-1:0] instr_count;

    ctrl_sequencer_if #(.IR_W(32)) bus ();

    ctrl_sequencer #(
        .IR_W(32), .OP_W(5), .COND_LSB(21), .MEM_TIMEOUT(TO), .CNT_W(CW)
    ) dut (
        .clock(clock), .nRst(nRst), .bus(bus), .state(state),
        .halted(halted), .fault(fault), .instr_count(instr_count)
    );

    always #5 clock = ~clock;

    obs_t          exp_q[$];
    obs_t          mon_e;
    int            total = 0;
    int            bad   = 0;
    logic [CW-1:0] count_m;
    logic          halted_m, fault_m;
    logic [31:0]   cur_ir;
    logic          cur_z, cur_n;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.st = state;        o.mem_rd = bus.mem_rd;   o.mem_wr = bus.mem_wr;
        o.ir_en = bus.ir_enable; o.pc_en = bus.pc_enable; o.pc_ld = bus.pc_load;
        o.ra = bus.ra_enable; o.rb = bus.rb_enable;  o.rz = bus.rz_enable;
        o.hilo = bus.hilo_enable; o.rfw = bus.rf_write;
        o.alu = bus.alu_control; o.sel = bus.my_select;
        o.hlt = halted; o.flt = fault; o.cnt = instr_count;
        return o;
    endfunction

    function automatic obs_t mk(input int st);
        obs_t e;
        e = '0;
        e.st = 3'(st); e.hlt = halted_m; e.flt = fault_m; e.cnt = count_m;
        return e;
    endfunction

    function automatic logic illegal(input logic [4:0] op);
        return (op == 5'd22) || (op == 5'd23) || (op == 5'd26) || (op >= 5'd29);
    endfunction

    function automatic logic [3:0] alu_of(input logic [4:0] op);
        case (op)
            5'd4:  return 4'd1;   5'd5:  return 4'd2;   5'd6:  return 4'd3;
            5'd7:  return 4'd4;   5'd8:  return 4'd5;   5'd9:  return 4'd6;
            5'd10: return 4'd7;   5'd11: return 4'd8;   5'd13: return 4'd2;
            5'd14: return 4'd3;   5'd15: return 4'd9;   5'd16: return 4'd10;
            5'd17: return 4'd11;  5'd18: return 4'd12;
            default: return 4'd0;
        endcase
    endfunction

    // Monitor: one expected vector per cycle, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk($sformatf("cycle_st%0d", mon_e.st), {6'd0, sample()}, {6'd0, mon_e});
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input obs_t e, input logic rdy);
        @(posedge clock);
        #1;
        bus.ir = cur_ir; bus.zero = cur_z; bus.rz_b31 = cur_n; bus.mem_ready = rdy;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clock);
        #1;
        nRst = 1'b0;
        count_m = '0; halted_m = 1'b0; fault_m = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_strobes", {12'd0, bus.mem_rd, bus.mem_wr, bus.ir_enable, bus.pc_enable,
            bus.pc_load, bus.ra_enable, bus.rb_enable, bus.rz_enable, bus.hilo_enable,
            bus.rf_write, bus.alu_control, bus.my_select}, 32'd0);
        chk("rst_status", {26'd0, halted, fault, instr_count}, 32'd0);
        nRst = 1'b1;
        exp_q.push_back(mk(0));
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) cyc(mk(halted_m ? 6 : 7), 1'($urandom));
    endtask

    // Reference model: one instruction, fw/mw stall cycles in fetch/memory.
    task automatic run_instr(input logic [4:0] op, input logic [1:0] cond, input logic z,
                             input logic n, input int fw, input int mw, input bit abort);
        obs_t e;
        logic taken;
        cur_ir = {op, 27'($urandom)};
        cur_ir[22:21] = cond;
        cur_z = z; cur_n = n;
        for (int i = 0; i < fw && i < TO; i++) begin
            e = mk(1); e.mem_rd = 1'b1; cyc(e, 1'b0);
        end
        if (fw >= TO) begin fault_m = 1'b1; return; end
        e = mk(1); e.mem_rd = 1'b1; e.ir_en = 1'b1; e.pc_en = 1'b1; cyc(e, 1'b1);
        e = mk(2); e.ra = 1'b1; e.rb = 1'b1; cyc(e, 1'($urandom));
        if (op == 5'd27) begin count_m++; return; end
        if (op == 5'd28) begin halted_m = 1'b1; return; end
        if (illegal(op)) begin fault_m = 1'b1; return; end
        case (cond)
            2'd0:    taken = z;
            2'd2:    taken = !z;
            2'd1:    taken = !n;
            default: taken = n;
        endcase
        e = mk(3); e.rz = 1'b1; e.alu = alu_of(op);
        e.hilo = (op == 5'd15) || (op == 5'd16);
        if (op == 5'd20 || op == 5'd21 || (op == 5'd19 && taken)) begin
            e.pc_en = 1'b1; e.pc_ld = 1'b1;
        end
        cyc(e, 1'($urandom));
        if (op == 5'd15 || op == 5'd16 || op == 5'd19 || op == 5'd21) begin count_m++; return; end
        if (op == 5'd0 || op == 5'd2) begin
            for (int i = 0; i < mw && i < TO; i++) begin
                e = mk(4); e.mem_rd = (op == 5'd0); e.mem_wr = (op == 5'd2); cyc(e, 1'b0);
                if (abort) begin
                    @(negedge clock);
                    #1;
                    nRst = 1'b0;
                    #1;
                    chk("abort_state", 32'(state), 32'd0);
                    chk("abort_mem_wr", 32'(bus.mem_wr), 32'd0);
                    chk("abort_rf_write", 32'(bus.rf_write), 32'd0);
                    return;
                end
            end
            if (mw >= TO) begin fault_m = 1'b1; return; end
            e = mk(4); e.mem_rd = (op == 5'd0); e.mem_wr = (op == 5'd2); cyc(e, 1'b1);
            if (op == 5'd2) begin count_m++; return; end
        end
        e = mk(5); e.rfw = 1'b1;
        if (op == 5'd0 || op == 5'd1) e.sel = 3'd2;
        else if (op == 5'd20)         e.sel = 3'd4;
        else if (op == 5'd24)         e.sel = 3'd3;
        else if (op == 5'd25)         e.sel = 3'd1;
        else                          e.sel = 3'd0;
        cyc(e, 1'($urandom));
        count_m++;
    endtask

    initial begin
        logic [4:0] op;
        int fw, mw;
        bus.ir = 32'd0; bus.zero = 1'b0; bus.rz_b31 = 1'b0; bus.mem_ready = 1'b0;
        cur_ir = 32'd0; cur_z = 1'b0; cur_n = 1'b0;
        do_reset();
        run_instr(5'd3, 2'd0, 1'b0, 1'b0, 0, 0, 1'b0);
        run_instr(5'd0, 2'd0, 1'b0, 1'b0, 0, 3, 1'b0);
        run_instr(5'd19, 2'd3, 1'b0, 1'b1, 0, 0, 1'b0);
        run_instr(5'd19, 2'd3, 1'b0, 1'b0, 0, 0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            run_instr(5'd19, 2'(c), 1'b0, 1'b0, 1, 0, 1'b0);
            run_instr(5'd19, 2'(c), 1'b1, 1'b1, 0, 0, 1'b0);
        end
        run_instr(5'd1, 2'd0, 1'b0, 1'b0, TO - 1, 0, 1'b0);
        run_instr(5'd2, 2'd0, 1'b0, 1'b0, 0, TO - 1, 1'b0);
        do_reset();
        repeat (17) run_instr(5'd27, 2'd0, 1'b0, 1'b0, 0, 0, 1'b0);
        for (int k = 0; k < 120; k++) begin
            do op = 5'($urandom_range(0, 27)); while (illegal(op));
            fw = ($urandom_range(0, 7) == 0) ? $urandom_range(3, TO - 1) : $urandom_range(0, 2);
            mw = ($urandom_range(0, 7) == 0) ? $urandom_range(3, TO - 1) : $urandom_range(0, 2);
            run_instr(op, 2'($urandom), 1'($urandom), 1'($urandom), fw, mw, 1'b0);
        end
        run_instr(5'd3, 2'd0, 1'b0, 1'b0, TO, 0, 1'b0);
        hold(4);
        do_reset();
        run_instr(5'd3, 2'd0, 1'b0, 1'b0, 0, 0, 1'b0);
        run_instr(5'd2, 2'd0, 1'b0, 1'b0, 0, TO, 1'b0);
        hold(3);
        do_reset();
        run_instr(5'd0, 2'd0, 1'b0, 1'b0, 1, TO, 1'b0);
        hold(2);
        do_reset();
        run_instr(5'd31, 2'd0, 1'b0, 1'b0, 0, 0, 1'b0);
        hold(3);
        do_reset();
        run_instr(5'd22, 2'd0, 1'b0, 1'b0, 0, 0, 1'b0);
        hold(2);
        do_reset();
        run_instr(5'd5, 2'd0, 1'b0, 1'b0, 0, 0, 1'b0);
        run_instr(5'd28, 2'd0, 1'b0, 1'b0, 0, 0, 1'b0);
        hold(4);
        do_reset();
        run_instr(5'd2, 2'd0, 1'b0, 1'b0, 0, 5, 1'b1);
        do_reset();
        run_instr(5'd20, 2'd0, 1'b0, 1'b0, 0, 0, 1'b0);
        @(negedge clock);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
Parametrised multi-cycle control unit for the MiniSRC datapath, replacing the fixed 5-cycle ring counter. Sequencing is an explicit FSM whose per-instruction path length depends on opcode class. It stalls on a memory ready handshake, faults on illegal opcodes and memory timeouts, halts on a halt opcode, and counts retired instructions. Sits between the instruction register/memory interface and the datapath register enables and muxes.

Parameters:
IR_W, 32, instruction width; opcode is ir[IR_W-1 -: OP_W]
OP_W, 5, opcode field width
COND_LSB, 21, LSB of the 2-bit branch condition field ir[COND_LSB+1:COND_LSB]
MEM_TIMEOUT, 15, max consecutive cycles mem_ready may stay low in FETCH or MEM before FAULT (>=1)
CNT_W, 32, retired-instruction counter width

Ports:
clock  in  1  system clock, rising edge
nRst  in  1  asynchronous active-low reset
ir  in  IR_W  registered instruction word
zero  in  1  datapath zero flag (from the value being branch-tested)
rz_b31  in  1  sign bit of the tested value
mem_ready  in  1  memory completes the current read/write this cycle
mem_rd, mem_wr  out  1  memory read/write request
ir_enable, pc_enable  out  1  load IR; load PC
pc_load  out  1  1: PC takes target (branch/jal/jr); 0: PC+1
ra_enable, rb_enable, rz_enable, hilo_enable  out  1  datapath register enables
rf_write  out  1  register-file write strobe
alu_control  out  4  ALU operation
my_select  out  3  writeback mux: 0 ALU, 1 HI, 2 memory, 3 LO, 4 PC return
state  out  3  current FSM state
halted, fault  out  1  sticky status flags
instr_count  out  CNT_W  retired-instruction count

Behaviour:
- nRst low asynchronously: state=IDLE, wait counter=0, instr_count=0, halted=0, fault=0. All outputs decode from the registered state, so every strobe is 0 and alu_control/my_select are 0 while in reset.
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, FAULT=7. IDLE goes to FETCH unconditionally on the first edge after reset release.
- FETCH: mem_rd=1.
  - mem_ready=1: ir_enable=1, pc_enable=1, pc_load=0, go to DECODE.
  - Otherwise stay and increment the wait counter.
- DECODE: ra_enable=rb_enable=1. Next state by opcode:
  - nop 11011: retire, go to FETCH.
  - halt 11100: go to HALT.
  - Undefined opcode: go to FAULT.
  - All others: go to EXEC.
- EXEC: rz_enable=1; alu_control per table (add 00011=0, sub=1, and=2, or=3, rotr=4, rotl=5, shr=6, shra=7, shl=8, addi 01100=0, andi=2, ori=3, div 01111=9, mul 10000=10, neg=11, not=12; ld/ldi/st use 0 for address). Next state:
  - ld 00000, st 00010: go to MEM.
  - ldi 00001, ALU ops, jal 10100, mflo 11000, mfhi 11001: go to WB.
  - div/mul: hilo_enable=1, retire, go to FETCH.
  - br 10011: retire, go to FETCH. pc_enable=pc_load=1 if taken. cond 00: taken if zero; 10: if ~zero; 01: if ~rz_b31; 11: if rz_b31.
  - jal, jr 10101: pc_enable=pc_load=1. jr retires and goes to FETCH.
- MEM: mem_rd=1 for ld, mem_wr=1 for st; the request is held until mem_ready=1.
  - ld: go to WB.
  - st: retire, go to FETCH.
- WB: rf_write=1. my_select: 2 for ld/ldi, 4 for jal, 3 for mflo, 1 for mfhi, else 0. Retire, go to FETCH.
- Wait counter: clears on entering FETCH or MEM and on mem_ready=1. When it reaches MEM_TIMEOUT with mem_ready still 0, go to FAULT. mem_ready on the timeout cycle wins.
- Retire: instr_count += 1 on the edge leaving the final state. Wraps modulo 2^CNT_W.
- HALT and FAULT: absorbing; all strobes 0; only nRst exits. halted=1 in HALT, fault=1 in FAULT. The count is frozen.
- Latency with zero memory wait: nop 2; br/jr/mul/div 3; ALU/ldi/jal/mflo/mfhi/st 4; ld 5. Each memory wait cycle adds 1.
- Reset mid-operation: a pending mem_rd/mem_wr drops immediately; no write strobe may glitch.

Decomposition:
- Package ctrl_pkg holds:
  - state encoding;
  - opcode constants;
  - ALU op codes;
  - my_select codes;
  - branch condition codes.
- One sub-module, ctrl_decode: purely combinational. Maps opcode to class (alu, hilo, load, store, branch, jump, move, nop, halt, illegal), alu_control and my_select. The sequencer instantiates it.

Test Plan:
- Reset then add (ir=0x18000000), mem_ready tied 1 -> FETCH, DECODE, EXEC, WB; rf_write high only in WB; instr_count=1 after 5 cycles from IDLE.
- ld with mem_ready low 3 cycles in MEM -> mem_rd held 4 cycles; WB has my_select=2; total 8 cycles.
- br, cond 11, rz_b31=1 -> pc_load=pc_enable=1 in EXEC; same with rz_b31=0 -> pc_enable=0; both retire.
- mem_ready stuck 0 in FETCH with MEM_TIMEOUT=15 -> FAULT after 15 wait cycles; fault=1; instr_count unchanged; no strobes.
- Opcode 11111 -> FAULT from DECODE. Halt opcode -> HALT, halted=1. nRst pulse mid-MEM -> IDLE and mem_wr=0 the same cycle.
- 2^CNT_W nops with CNT_W=4 -> instr_count wraps 15 to 0.
